// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, BAUD_MULT clocks per bit.
// The line is resynchronised through two flops, the start bit is re-checked
// at its mid-point, and each data/stop bit is sampled one full bit period
// after the previous sample point.
// Optional feature macro: UART_RX_FRAME_ERR_EN adds the stop-bit check, the
// o_frame_err pulse and a WAIT_HIGH state that holds until the line recovers.
module uart_rx #(
    parameter int unsigned BAUD_MULT = 139
) (
    input  logic       i_uart_clk,
    input  logic       i_rst,
    input  logic       i_rx_data,
    output logic [7:0] o_byte_out,
    output logic       o_data_valid,
    output logic       o_rx_active
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       o_frame_err
`endif
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    // Counter values at which the start bit and the data/stop bits are sampled
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((BAUD_MULT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_MULT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

`ifdef UART_RX_FRAME_ERR_EN
    localparam int unsigned STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;
`else
    localparam int unsigned STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    logic              sync_meta;
    logic              line;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] byte_next;
    logic              valid_next;
    logic              active_next;
`ifdef UART_RX_FRAME_ERR_EN
    logic              ferr_next;
`endif

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge i_uart_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_meta <= 1'b1;
            line      <= 1'b1;
        end else begin
            sync_meta <= i_rx_data;
            line      <= sync_meta;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        byte_next  = o_byte_out;
        valid_next = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_next  = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (!line) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end

            START: begin
                if (cnt == HALF_CNT) begin
                    if (!line) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt == FULL_CNT) begin
                    shift_next = {line, shift[DATA_W-1:1]};
                    cnt_next   = '0;
                    if (idx == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt == FULL_CNT) begin
                    cnt_next = '0;
`ifdef UART_RX_FRAME_ERR_EN
                    if (line) begin
                        byte_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
`else
                    byte_next  = shift;
                    valid_next = 1'b1;
                    state_next = IDLE;
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

`ifdef UART_RX_FRAME_ERR_EN
            WAIT_HIGH: begin
                // Hold off until the broken frame releases the line
                if (line) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase

        active_next = (state_next == START) || (state_next == DATA) ||
                      (state_next == STOP);
    end

    // State, datapath and registered outputs
    always_ff @(posedge i_uart_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            o_byte_out   <= 8'h00;
            o_data_valid <= 1'b0;
            o_rx_active  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            o_frame_err  <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            shift        <= shift_next;
            o_byte_out   <= byte_next;
            o_data_valid <= valid_next;
            o_rx_active  <= active_next;
`ifdef UART_RX_FRAME_ERR_EN
            o_frame_err  <= ferr_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized + directed frames at 16 clocks/bit. The driver
// pushes the expected byte and arrival cycle into a queue; a monitor on the
// falling clock edge pops and compares whenever the receiver reports.
module tb_uart_rx;

    localparam int unsigned B    = 16;
    localparam int unsigned HALF = (B - 1) / 2;
    // Frame start (first edge seeing the line low) to the cycle the valid
    // or error pulse is visible: 9.5 bit periods plus resync/decision delay.
    localparam int unsigned LAT  = 9 * B + HALF + 4;

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [7:0]  byte_out;
    logic        data_valid;
    logic        rx_active;
`ifdef UART_RX_FRAME_ERR_EN
    logic        frame_err;
`endif

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t        exp_q[$];
    int unsigned ferr_q[$];
    logic [7:0]  last_byte = 8'h00;

    uart_rx #(.BAUD_MULT(B)) dut (
        .i_uart_clk  (clk),
        .i_rst       (rst),
        .i_rx_data   (rx),
        .o_byte_out  (byte_out),
        .o_data_valid(data_valid),
        .o_rx_active (rx_active)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .o_frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding frame
    always @(negedge clk) begin
        if (!rst && data_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got byte %0h at cycle %0d, none required", byte_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_byte", 32'(byte_out), 32'(e.data));
                check("valid_cycle", cyc, e.cyc);
            end
        end
`ifdef UART_RX_FRAME_ERR_EN
        if (!rst && frame_err) begin
            if (ferr_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame_err: got pulse at cycle %0d, none required", cyc);
            end else begin
                int unsigned fc;
                fc = ferr_q.pop_front();
                check("frame_err_cycle", cyc, fc);
            end
        end
`endif
    end

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame starting at the current falling edge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        exp_t e;
        e.data = b;
        e.cyc  = cyc + LAT;
`ifdef UART_RX_FRAME_ERR_EN
        if (stop_bit) begin
            exp_q.push_back(e);
            last_byte = b;
        end else begin
            ferr_q.push_back(cyc + LAT);
        end
`else
        exp_q.push_back(e);
        last_byte = b;
`endif
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = stop_bit;
        repeat (B) @(negedge clk);
        rx = 1'b1;
    endtask

    // 0xFF frame with reset pulsed in the middle of data bit 4
    task automatic send_ff_with_reset();
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = 1'b1;
            if (i == 4) begin
                check("mid_frame_active", 32'(rx_active), 32'd1);
                repeat (B / 2) @(negedge clk);
                rst = 1'b1;
                #1;
                check("rst_byte_out", 32'(byte_out), 32'd0);
                check("rst_valid", 32'(data_valid), 32'd0);
                check("rst_active", 32'(rx_active), 32'd0);
                last_byte = 8'h00;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (B / 2 - 2) @(negedge clk);
            end else begin
                repeat (B) @(negedge clk);
            end
        end
        rx = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_byte_out", 32'(byte_out), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_active", 32'(rx_active), 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
        check("reset_frame_err", 32'(frame_err), 32'd0);
`endif
        rst = 1'b0;
        idle(5);

        // Single frame, then two frames back to back
        send_frame(8'h55, 1'b1);
        idle(10);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(2 * B);
        check("idle_active", 32'(rx_active), 32'd0);

        // Short low glitch on an idle line must be rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check("glitch_active_start", 32'(rx_active), 32'd1);
        repeat (2 * B) @(negedge clk);
        check("glitch_active_end", 32'(rx_active), 32'd0);
        check("glitch_byte_hold", 32'(byte_out), 32'(last_byte));

        // Stop bit held low
        send_frame(8'h3C, 1'b0);
`ifdef UART_RX_FRAME_ERR_EN
        check("wait_high_active", 32'(rx_active), 32'd0);
        check("ferr_byte_hold", 32'(byte_out), 32'(last_byte));
`endif
        idle(3 * B);
        send_frame(8'h81, 1'b1);
        idle(3 * B);
        check("byte_81_hold", 32'(byte_out), 32'h81);

        // Reset mid-frame, then normal reception resumes
        send_ff_with_reset();
        idle(2 * B);
        check("after_rst_byte", 32'(byte_out), 32'd0);
        check("after_rst_active", 32'(rx_active), 32'd0);
        send_frame(8'h12, 1'b1);
        idle(5);

        // Random bytes with random gaps, often back to back
        for (int k = 0; k < 24; k++) begin
            send_frame(8'($urandom), 1'b1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 40));
        end

        idle(3 * B);
        check("pending_valid", 32'(exp_q.size()), 32'd0);
        check("pending_frame_err", 32'(ferr_q.size()), 32'd0);
        check("final_byte_hold", 32'(byte_out), 32'(last_byte));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, %0d frames still pending", exp_q.size());
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter BAUD_MULT, default 139, giving the number of i_uart_clk cycles per bit (139 at 16 MHz ≈ 115200 baud); the legal range SHALL be 4..255.
REQ-002 The block SHALL have port i_uart_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_rx_data, input, 1 bit: the serial line, asynchronous to i_uart_clk, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port o_byte_out, output, 8 bits: the last correctly received byte.
REQ-006 The block SHALL have port o_data_valid, output, 1 bit: a one-cycle pulse marking a new byte on o_byte_out.
REQ-007 The block SHALL have port o_rx_active, output, 1 bit: high while a frame is being received.
REQ-008 The block SHALL have port o_frame_err, output, 1 bit: a one-cycle pulse on a bad stop bit; this port SHALL exist only when UART_RX_FRAME_ERR_EN is defined.

Function
REQ-009 i_rx_data SHALL pass through a 2-flop synchronizer before use; all line references below mean the synchronized value.
REQ-010 The FSM states SHALL be IDLE, START, DATA, STOP, plus WAIT_HIGH when UART_RX_FRAME_ERR_EN is defined.
REQ-011 In IDLE:
- line low -> START, with the bit counter cleared to 0.
- otherwise stay in IDLE.
REQ-012 In START, at bit counter == (BAUD_MULT-1)/2 (integer division):
- line low -> DATA, with the bit counter and data-bit index cleared.
- line high -> IDLE (glitch rejected; no output change).
REQ-013 In DATA, at bit counter == BAUD_MULT-1:
- sample the line into the shift register MSB and shift right (LSB first).
- clear the bit counter.
- after the 8th sample -> STOP.
REQ-014 In STOP, at bit counter == BAUD_MULT-1:
- line high -> o_byte_out <= shift register, o_data_valid = 1 for exactly one cycle, -> IDLE.
REQ-015 In every state except IDLE, the bit counter SHALL increment by 1 each cycle when its terminal condition is not met; it is 8 bits wide and SHALL never wrap in legal configurations.
REQ-016 o_rx_active SHALL be 1 in START, DATA and STOP, and 0 in IDLE and WAIT_HIGH.
REQ-017 o_byte_out SHALL hold its value until the next valid byte; it SHALL never change on glitches or frame errors.
REQ-018 Latency: o_data_valid SHALL be high in the cycle after clock edge 9*BAUD_MULT + (BAUD_MULT-1)/2 + 3, where edge 0 is the first edge that samples the raw line low.
REQ-019 Back-to-back frames (the stop bit followed immediately by a start bit) SHALL be received without loss.

Reset
REQ-020 While i_rst = 1, asynchronously:
- state = IDLE.
- both synchronizer flops = 1.
- counters and shift register = 0.
- o_byte_out = 8'h00.
- o_data_valid, o_rx_active and o_frame_err = 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no o_data_valid; after reset release, reception SHALL resume at the next falling edge.

Configuration
REQ-022 With macro UART_RX_FRAME_ERR_EN defined, a STOP sample of 0 SHALL:
- pulse o_frame_err for one cycle.
- suppress o_data_valid.
- move to WAIT_HIGH, which returns to IDLE only when the line is high.
REQ-023 Without UART_RX_FRAME_ERR_EN, the stop bit SHALL NOT be checked: the byte is delivered with o_data_valid regardless, the FSM returns to IDLE, and o_frame_err and WAIT_HIGH do not exist.

Verification (BAUD_MULT = 16)
REQ-024 Drive frame 0x55 at 16 cycles/bit -> o_data_valid is high exactly one cycle, after edge 154, with o_byte_out = 8'h55.
REQ-025 Drive 0xA3 then 0x0F back-to-back -> two valid pulses, 160 cycles apart, carrying 8'hA3 then 8'h0F.
REQ-026 Drive a 4-cycle low glitch on an idle line -> no o_data_valid, o_rx_active returns to 0, o_byte_out unchanged.
REQ-027 Drive 0x3C with the stop bit held low:
- macro defined: o_frame_err pulses, no valid, FSM waits for the line high, then 0x81 is received correctly.
- macro undefined: valid with 8'h3C.
REQ-028 Assert i_rst during bit 4 of 0xFF -> outputs go to 0 immediately, no valid pulse, and the following 0x12 is received correctly.
